// File: rtl/rst_sequencer_if.sv
// Signal bundle between the reset sequencer and its environment.
// The sequencer takes the slave view; whoever drives lock/soft-reset takes the master view.
interface rst_sequencer_if;
   logic       i_pll_lock;
   logic       i_soft_rst;
   logic [2:0] o_rst_n;
   logic       o_ready;
   logic [2:0] o_state;
   logic [7:0] o_lock_loss_cnt;

   modport master (
      output i_pll_lock,
      output i_soft_rst,
      input  o_rst_n,
      input  o_ready,
      input  o_state,
      input  o_lock_loss_cnt
   );

   modport slave (
      input  i_pll_lock,
      input  i_soft_rst,
      output o_rst_n,
      output o_ready,
      output o_state,
      output o_lock_loss_cnt
   );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset release after PLL lock: waits for a stable lock window, then
// releases three reset domains one gap apart and raises ready.
module rst_sequencer #(
   parameter int unsigned LOCK_STABLE_CYC = 1000,
   parameter int unsigned STAGE_GAP_CYC   = 500,
   parameter int unsigned CNT_W           = 16
) (
   input logic            i_clk,
   input logic            i_rst_n,
   rst_sequencer_if.slave io_bus
);

   typedef enum logic [2:0] {
      StWaitLock = 3'd0,
      StStable   = 3'd1,
      StRel0     = 3'd2,
      StRel1     = 3'd3,
      StRel2     = 3'd4,
      StRun      = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] GapLast  = CNT_W'(STAGE_GAP_CYC - 1);

   logic             r_sync1;
   logic             r_sync2;
   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_rst_n;
   logic             r_ready;
   logic [7:0]       r_loss_cnt;

   state_e           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [7:0]       w_loss_nxt;
   logic [2:0]       w_rst_n_nxt;
   logic             w_ready_nxt;
   logic             w_lock_s;
   logic             w_gap_done;

   assign w_lock_s   = r_sync2;
   assign w_gap_done = (r_cnt == GapLast);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_loss_nxt  = r_loss_cnt;
      unique case (r_state)
         StWaitLock: begin
            w_cnt_nxt = '0;
            if (w_lock_s) w_state_nxt = StStable;
         end
         StStable, StRel0, StRel1, StRel2, StRun: begin
            // Lock loss outranks soft reset and any stage advance.
            if (!w_lock_s) begin
               w_state_nxt = StWaitLock;
               w_cnt_nxt   = '0;
               if (r_loss_cnt != 8'hFF) w_loss_nxt = r_loss_cnt + 8'd1;
            end else if (io_bus.i_soft_rst) begin
               w_state_nxt = StStable;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
               case (r_state)
                  StStable: if (r_cnt == LockLast) w_state_nxt = StRel0;
                  StRel0:   if (w_gap_done) w_state_nxt = StRel1;
                  StRel1:   if (w_gap_done) w_state_nxt = StRel2;
                  StRel2:   if (w_gap_done) w_state_nxt = StRun;
                  default:  w_cnt_nxt = '0;
               endcase
               if (w_state_nxt != r_state) w_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = StWaitLock;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so each bit flips on the entry edge.
   always_comb begin
      w_rst_n_nxt = 3'b000;
      w_ready_nxt = 1'b0;
      case (w_state_nxt)
         StRel0:  w_rst_n_nxt = 3'b001;
         StRel1:  w_rst_n_nxt = 3'b011;
         StRel2:  w_rst_n_nxt = 3'b111;
         StRun: begin
            w_rst_n_nxt = 3'b111;
            w_ready_nxt = 1'b1;
         end
         default: w_rst_n_nxt = 3'b000;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_state    <= StWaitLock;
         r_cnt      <= '0;
         r_rst_n    <= 3'b000;
         r_ready    <= 1'b0;
         r_loss_cnt <= 8'd0;
      end else begin
         r_sync1    <= io_bus.i_pll_lock;
         r_sync2    <= r_sync1;
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_rst_n    <= w_rst_n_nxt;
         r_ready    <= w_ready_nxt;
         r_loss_cnt <= w_loss_nxt;
      end
   end

   assign io_bus.o_rst_n         = r_rst_n;
   assign io_bus.o_ready         = r_ready;
   assign io_bus.o_state         = r_state;
   assign io_bus.o_lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus random lock toggling, checked
// every cycle against a timeline model (time since sequence start).
module tb_rst_sequencer;
   localparam int L = 10;
   localparam int G = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   rst_sequencer_if bus ();

   rst_sequencer #(
      .LOCK_STABLE_CYC(L),
      .STAGE_GAP_CYC  (G),
      .CNT_W          (16)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_bus (bus)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Model: synchronizer pipe, whether a sequence is active, cycles since it began.
   logic m_s1, m_s2;
   bit   m_in_seq;
   int   m_t;
   int   m_loss;

   function automatic int m_state();
      if (!m_in_seq) return 0;
      if (m_t < L) return 1;
      if (m_t < L + G) return 2;
      if (m_t < L + 2 * G) return 3;
      if (m_t < L + 3 * G) return 4;
      return 5;
   endfunction

   function automatic logic [2:0] m_rst_n();
      if (!m_in_seq) return 3'b000;
      return {m_t >= L + 2 * G, m_t >= L + G, m_t >= L};
   endfunction

   task automatic model_reset();
      m_s1 = 1'b0; m_s2 = 1'b0; m_in_seq = 0; m_t = 0; m_loss = 0;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      check("rst_n", {5'd0, bus.o_rst_n}, {5'd0, m_rst_n()});
      check("ready", {7'd0, bus.o_ready}, {7'd0, m_state() == 5});
      check("state", {5'd0, bus.o_state}, 8'(m_state()));
      check("loss_cnt", bus.o_lock_loss_cnt, 8'(m_loss));
   endtask

   task automatic step();
      logic lk, sf;
      lk = m_s2;
      sf = bus.i_soft_rst;
      @(posedge clk);
      if (m_in_seq) begin
         if (!lk) begin
            m_in_seq = 0; m_t = 0;
            if (m_loss < 255) m_loss++;
         end else if (sf) m_t = 0;
         else if (m_t < L + 3 * G) m_t++;
      end else if (lk) begin
         m_in_seq = 1; m_t = 0;
      end
      m_s2 = m_s1;
      m_s1 = bus.i_pll_lock;
      #1;
      cyc++;
      check_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Step until the model reaches state st (and time tt if tt >= 0), bounded.
   task automatic wait_model(input int st, input int tt, input int budget);
      bit hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         if (m_state() == st && (tt < 0 || m_t == tt)) hit = 1;
         else step();
      end
      if (m_state() == st && (tt < 0 || m_t == tt)) hit = 1;
      n_checks++;
      assert (hit) else begin
         n_err++;
         $error("FAIL wait_state cycle=%0d observed=%0d expected=%0d", cyc, m_state(), st);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rst_n"}, {5'd0, bus.o_rst_n}, 8'd0);
      check({tag, "_ready"}, {7'd0, bus.o_ready}, 8'd0);
      check({tag, "_state"}, {5'd0, bus.o_state}, 8'd0);
      check({tag, "_loss"}, bus.o_lock_loss_cnt, 8'd0);
   endtask

   initial begin
      int hi, lo;
      bus.i_pll_lock = 1'b0;
      bus.i_soft_rst = 1'b0;
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("por");
      @(posedge clk);
      #1 check_reset_outputs("por_clk");
      #3 rst_n = 1'b1;
      bus.i_pll_lock = 1'b1;

      // Lock held: full release sequence into RUN.
      steps(L + 3 * G + 8);
      check("run_reached", {5'd0, bus.o_state}, 8'd5);

      // Drop lock, re-lock, then a one-cycle drop that lands at stability count 6.
      bus.i_pll_lock = 1'b0;
      steps(4);
      bus.i_pll_lock = 1'b1;
      wait_model(1, 4, 20);
      bus.i_pll_lock = 1'b0;
      step();
      bus.i_pll_lock = 1'b1;
      wait_model(5, -1, 60);

      // Lock loss in RUN, then replay.
      bus.i_pll_lock = 1'b0;
      steps(5);
      bus.i_pll_lock = 1'b1;
      wait_model(5, -1, 60);

      // Soft reset pulse in REL1.
      bus.i_pll_lock = 1'b0;
      steps(3);
      bus.i_pll_lock = 1'b1;
      wait_model(3, -1, 60);
      bus.i_soft_rst = 1'b1;
      step();
      bus.i_soft_rst = 1'b0;
      check("soft_state", {5'd0, bus.o_state}, 8'd1);
      wait_model(5, -1, 60);

      // Soft reset coincident with synchronized lock loss in RUN.
      bus.i_pll_lock = 1'b0;
      steps(2);
      bus.i_soft_rst = 1'b1;
      step();
      bus.i_soft_rst = 1'b0;
      check("soft_loss_state", {5'd0, bus.o_state}, 8'd0);

      // Random lock chatter with occasional soft resets; drives loss count to saturation.
      for (int k = 0; k < 300; k++) begin
         hi = $urandom_range(1, 4);
         lo = $urandom_range(2, 3);
         bus.i_pll_lock = 1'b1;
         for (int j = 0; j < hi; j++) begin
            bus.i_soft_rst = ($urandom_range(0, 3) == 0);
            step();
         end
         bus.i_soft_rst = 1'b0;
         bus.i_pll_lock = 1'b0;
         steps(lo);
      end
      steps(3);
      check("loss_sat", bus.o_lock_loss_cnt, 8'd255);

      // Asynchronous reset mid-REL2, between clock edges.
      bus.i_pll_lock = 1'b1;
      wait_model(4, -1, 80);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("async");
      model_reset();
      @(posedge clk);
      #1 check_reset_outputs("async_clk");
      #3 rst_n = 1'b1;
      steps(L + 3 * G + 6);
      check("rerun_state", {5'd0, bus.o_state}, 8'd5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
- REQ-001 SHALL have parameter LOCK_STABLE_CYC, default 1000: consecutive synchronized lock-high cycles required before sequencing begins.
- REQ-002 SHALL have parameter STAGE_GAP_CYC, default 500: cycles between successive stage releases.
- REQ-003 SHALL have parameter CNT_W, default 16: internal counter width; LOCK_STABLE_CYC and STAGE_GAP_CYC SHALL each be in 1..2^CNT_W-1.
- REQ-004 i_clk  input  1  single clock, the PLL 50 MHz primary output; all logic is on its rising edge.
- REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
- REQ-006 i_pll_lock  input  1  PLL lock indicator, asynchronous to i_clk.
- REQ-007 i_soft_rst  input  1  synchronous single-cycle request to restart the sequence.
- REQ-008 o_rst_n  output  3  per-stage active-low resets; bit0 releases first, bit2 last.
- REQ-009 o_ready  output  1  high only when all stages are released.
- REQ-010 o_state  output  3  current FSM state encoding, for debug.
- REQ-011 o_lock_loss_cnt  output  8  count of lock-loss events, saturating.

Function
- REQ-012 i_pll_lock SHALL pass through a 2-flop synchronizer; lock_s is the second flop output, so there are 2 cycles of latency.
- REQ-013 FSM states SHALL be WAIT_LOCK=0, STABLE=1, REL0=2, REL1=3, REL2=4 and RUN=5; codes 6 and 7 SHALL go to WAIT_LOCK on the next cycle.
- REQ-014 WAIT_LOCK: counter held at 0, o_rst_n=3'b000; SHALL go to STABLE when lock_s=1.
- REQ-015 STABLE: counter increments each cycle while lock_s=1; SHALL go to REL0 when counter reaches LOCK_STABLE_CYC-1, clearing the counter.
- REQ-016 REL0: o_rst_n[0] SHALL go high on entry; counter counts to STAGE_GAP_CYC-1, then SHALL go to REL1 and clear.
- REQ-017 REL1: o_rst_n[1] SHALL go high on entry; after STAGE_GAP_CYC cycles SHALL go to REL2.
- REQ-018 REL2: o_rst_n[2] SHALL go high on entry; after STAGE_GAP_CYC cycles SHALL go to RUN.
- REQ-019 RUN: o_rst_n=3'b111 and o_ready=1; o_ready SHALL be 0 in every other state.
- REQ-020 o_rst_n and o_ready SHALL be registered and glitch-free; each stage bit, once released, SHALL stay high until a lock loss, soft reset or i_rst_n.
- REQ-021 Lock loss (lock_s=0) in any state other than WAIT_LOCK SHALL, on the next edge:
  - go to WAIT_LOCK;
  - set o_rst_n=3'b000 and o_ready=0;
  - clear the counter.
- REQ-022 A lock loss from STABLE, REL0, REL1, REL2 or RUN SHALL increment o_lock_loss_cnt by 1; the count saturates at 255 with no wrap.
- REQ-023 i_soft_rst=1 with lock_s=1 in any state except WAIT_LOCK SHALL, on the next edge:
  - go to STABLE;
  - set o_rst_n=3'b000 and o_ready=0;
  - clear the counter;
  - leave o_lock_loss_cnt unchanged.
- REQ-024 i_soft_rst in WAIT_LOCK SHALL be ignored.
- REQ-025 i_soft_rst and a lock loss in the same cycle: lock loss SHALL take priority (go to WAIT_LOCK and increment the count).
- REQ-026 The counter SHALL never wrap; it is cleared on every state transition.
- REQ-027 Latency from the first lock_s=1 cycle to o_rst_n[0] high SHALL be LOCK_STABLE_CYC+1 cycles.
- REQ-028 Latency from o_rst_n[0] high to o_rst_n[1] high, and from o_rst_n[1] to o_rst_n[2], SHALL each be exactly STAGE_GAP_CYC cycles.
- REQ-029 o_ready SHALL rise exactly STAGE_GAP_CYC cycles after o_rst_n[2].

Reset
- REQ-030 i_rst_n=0 SHALL asynchronously force:
  - state=WAIT_LOCK;
  - synchronizer flops, counter and o_lock_loss_cnt to 0;
  - o_rst_n=3'b000, o_ready=0, o_state=3'd0.
- REQ-031 Release of i_rst_n SHALL be sampled synchronously; the first transition out of WAIT_LOCK is possible no earlier than the 2nd edge after release.
- REQ-032 Assertion of i_rst_n mid-sequence (any state) SHALL produce the REQ-030 values immediately, without waiting for a clock edge.

Verification (LOCK_STABLE_CYC=10, STAGE_GAP_CYC=4)
- REQ-033 Lock held high from reset release -> o_rst_n[0] rises 11 cycles after lock_s first goes high, [1] 4 cycles later, [2] 4 cycles after that, o_ready 4 cycles after that; o_lock_loss_cnt=0.
- REQ-034 Lock drops for 1 cycle (after synchronization) during STABLE at count 6 -> return to WAIT_LOCK; the full 10-cycle stability window restarts; o_lock_loss_cnt=1.
- REQ-035 Lock drops while in RUN -> next edge o_rst_n=000 and o_ready=0, o_state=0, count increments; when lock returns, the sequence replays with the REQ-033 timing.
- REQ-036 i_soft_rst pulse in REL1 -> next edge o_rst_n=000 and o_state=1; o_rst_n[0] rises 10 cycles later; count unchanged.
- REQ-037 i_soft_rst and a lock drop in the same cycle in RUN -> o_state=0 and count increments; 300 lock-loss events -> o_lock_loss_cnt holds at 255.
- REQ-038 i_rst_n asserted asynchronously between edges during REL2 -> all outputs reach reset values before the next edge; o_lock_loss_cnt=0.
